cliente_cajero: RTL and testbench
=================================

CLIENTE_CAJERO -- requirements
Module: cliente_cajero

Interface
REQ-001 Parameter TIMEOUT, default 32, maximum wait cycles for any ATM response (used only with CLIENTE_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 iniciar  input  1  request to run one transaction; sampled only in IDLE.
REQ-005 pin_usuario  input  16  four BCD digits to send; [15:12] is the first digit.
REQ-006 tipo_usuario  input  1  transaction type; 0 = deposit, 1 = withdrawal.
REQ-007 monto_usuario  input  32  transaction amount.
REQ-008 pin_incorrecto, advertencia, bloqueo, balance_stb, entregar_dinero, fondos_insuficientes  input  1 each  ATM status lines.
REQ-009 balance_actualizado  input  64  ATM balance; valid when balance_stb=1.
REQ-010 tarjeta_recibida  output  1  card-inserted pulse to the ATM.
REQ-011 digito_stb  output  1  digit strobe; digito is valid only while it is high.
REQ-012 digito  output  4  current PIN digit.
REQ-013 tipo_trans  output  1  latched transaction type.
REQ-014 monto  output  32  latched transaction amount.
REQ-015 ocupado  output  1  high in every state except IDLE.
REQ-016 hecho  output  1  one-cycle completion pulse.
REQ-017 resultado  output  3  outcome code; valid from the hecho cycle until the next accepted iniciar.
REQ-018 balance_leido  output  64  balance captured on balance_stb.
REQ-019 advertencia_vista  output  1  sticky flag; set if advertencia seen during the current transaction.

Function
REQ-020 The FSM SHALL use states IDLE, TARJETA, DIGITO, PAUSA, ESPERA_PIN, ESPERA_RETIRO and FIN.
REQ-021 On iniciar=1 in IDLE at edge N, the block SHALL latch pin_usuario, tipo_usuario and monto_usuario, clear resultado, balance_leido and advertencia_vista, and enter TARJETA.
REQ-022 In TARJETA, tarjeta_recibida SHALL be high for exactly one cycle (cycle N+1).
REQ-023 DIGITO and PAUSA SHALL alternate four times, so digito_stb pulses for one cycle each at N+2, N+4, N+6 and N+8, sending digits MSB nibble first.
REQ-024 digito SHALL be 0 whenever digito_stb=0.
REQ-025 tipo_trans and monto SHALL drive the latched values from N+1 until return to IDLE, and be 0 in IDLE.
REQ-026 ESPERA_PIN is entered after the fourth PAUSA and SHALL resolve in this priority order:
  - bloqueo: resultado=100, go to FIN.
  - else pin_incorrecto: resultado=011, go to FIN.
  - else balance_stb: capture balance_actualizado into balance_leido; deposit gives resultado=001 and FIN; withdrawal goes to ESPERA_RETIRO.
REQ-027 In ESPERA_RETIRO:
  - entregar_dinero: resultado=010, go to FIN.
  - fondos_insuficientes: resultado=101, go to FIN.
  - both in the same cycle: fondos_insuficientes wins.
REQ-028 advertencia=1 in any non-IDLE state SHALL set advertencia_vista.
REQ-029 FIN SHALL assert hecho for one cycle, then enter IDLE.
REQ-030 iniciar SHALL be ignored while ocupado=1.
REQ-031 Unused resultado codes: 000 means no result; 111 is reserved and never driven.

Reset
REQ-032 reset=0 at any edge SHALL force IDLE on that edge, including mid-transaction.
REQ-033 After reset, every output SHALL be 0, including the 64-bit balance_leido and resultado=000.
REQ-034 No strobe SHALL be emitted in the cycle after reset is released.

Configuration
REQ-035 Macro CLIENTE_TIMEOUT_EN defined:
  - A wait counter SHALL clear on entry to ESPERA_PIN and ESPERA_RETIRO.
  - If TIMEOUT cycles elapse with no qualifying input, resultado=110 and the FSM goes to FIN.
  - A response arriving in the same cycle as the timeout SHALL win over the timeout.
REQ-036 Macro not defined: no counter is built, wait states wait indefinitely, and code 110 is never produced.

Verification
REQ-037 Deposit: pin 16'h1234, tipo 0, monto 500; ATM asserts balance_stb with 1500 at N+10 → digits 1,2,3,4 strobed at N+2/4/6/8; hecho at N+11; resultado=001; balance_leido=1500.
REQ-038 Withdrawal: tipo 1, monto 200; balance_stb with 800, then entregar_dinero 3 cycles later → resultado=010, balance_leido=800.
REQ-039 Wrong PIN with advertencia and pin_incorrecto in the same cycle → resultado=011, advertencia_vista=1; the same cycle with bloqueo also high → resultado=100.
REQ-040 Withdrawal with entregar_dinero and fondos_insuficientes asserted together → resultado=101; iniciar pulsed during the transaction is ignored.
REQ-041 reset=0 at N+5 → all outputs 0 next cycle; no further digito_stb; a new iniciar after release restarts at the first digit.
REQ-042 CLIENTE_TIMEOUT_EN defined, TIMEOUT=32, ATM silent → hecho 32 cycles after entering ESPERA_PIN with resultado=110; macro undefined → ocupado stays 1 for 200 cycles.

Source files
------------

// File: rtl/cliente_cajero_if.sv
// Client <-> ATM signal bundle for cliente_cajero.
// master: the client block (drives card/digit/result lines).
// slave : the user + ATM side (drives request and ATM status lines).
interface cliente_cajero_if;
  // user request
  logic        iniciar;
  logic [15:0] pin_usuario;
  logic        tipo_usuario;
  logic [31:0] monto_usuario;
  // ATM status
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        balance_stb;
  logic        entregar_dinero;
  logic        fondos_insuficientes;
  logic [63:0] balance_actualizado;
  // client outputs
  logic        tarjeta_recibida;
  logic        digito_stb;
  logic [3:0]  digito;
  logic        tipo_trans;
  logic [31:0] monto;
  logic        ocupado;
  logic        hecho;
  logic [2:0]  resultado;
  logic [63:0] balance_leido;
  logic        advertencia_vista;

  modport master (
    input  iniciar, pin_usuario, tipo_usuario, monto_usuario,
           pin_incorrecto, advertencia, bloqueo, balance_stb,
           entregar_dinero, fondos_insuficientes, balance_actualizado,
    output tarjeta_recibida, digito_stb, digito, tipo_trans, monto,
           ocupado, hecho, resultado, balance_leido, advertencia_vista
  );

  modport slave (
    output iniciar, pin_usuario, tipo_usuario, monto_usuario,
           pin_incorrecto, advertencia, bloqueo, balance_stb,
           entregar_dinero, fondos_insuficientes, balance_actualizado,
    input  tarjeta_recibida, digito_stb, digito, tipo_trans, monto,
           ocupado, hecho, resultado, balance_leido, advertencia_vista
  );
endinterface

// File: rtl/cliente_cajero.sv
// ATM client: sends card + 4 PIN digits, waits for the ATM verdict and
// reports a result code. Optional response timeout is built only when the
// macro CLIENTE_TIMEOUT_EN is defined (limit set by parameter TIMEOUT).
module cliente_cajero #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              reset,
  cliente_cajero_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, TARJETA, DIGITO, PAUSA, ESPERA_PIN, ESPERA_RETIRO, FIN
  } estado_t;

  localparam logic [2:0] RES_DEPOSITO = 3'b001;
  localparam logic [2:0] RES_RETIRO   = 3'b010;
  localparam logic [2:0] RES_PIN_MAL  = 3'b011;
  localparam logic [2:0] RES_BLOQUEO  = 3'b100;
  localparam logic [2:0] RES_FONDOS   = 3'b101;
`ifdef CLIENTE_TIMEOUT_EN
  localparam logic [2:0] RES_TIMEOUT  = 3'b110;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
`endif

  estado_t     estado_q, estado_d;
  logic [15:0] pin_q, pin_d;
  logic        tipo_q, tipo_d;
  logic [31:0] monto_q, monto_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  resultado_q, resultado_d;
  logic [63:0] balance_q, balance_d;
  logic        adv_q, adv_d;
`ifdef CLIENTE_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expira;
  assign expira = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT;
`endif

  // State and data registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q    <= IDLE;
      pin_q       <= '0;
      tipo_q      <= 1'b0;
      monto_q     <= '0;
      idx_q       <= '0;
      resultado_q <= '0;
      balance_q   <= '0;
      adv_q       <= 1'b0;
`ifdef CLIENTE_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      estado_q    <= estado_d;
      pin_q       <= pin_d;
      tipo_q      <= tipo_d;
      monto_q     <= monto_d;
      idx_q       <= idx_d;
      resultado_q <= resultado_d;
      balance_q   <= balance_d;
      adv_q       <= adv_d;
`ifdef CLIENTE_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state logic: request latch, digit sequencing, ATM response priority
  always_comb begin
    estado_d    = estado_q;
    pin_d       = pin_q;
    tipo_d      = tipo_q;
    monto_d     = monto_q;
    idx_d       = idx_q;
    resultado_d = resultado_q;
    balance_d   = balance_q;
    adv_d       = adv_q;
`ifdef CLIENTE_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (estado_q)
      IDLE: begin
        if (bus.iniciar) begin
          pin_d       = bus.pin_usuario;
          tipo_d      = bus.tipo_usuario;
          monto_d     = bus.monto_usuario;
          idx_d       = '0;
          resultado_d = '0;
          balance_d   = '0;
          adv_d       = 1'b0;
          estado_d    = TARJETA;
        end
      end
      TARJETA: estado_d = DIGITO;
      DIGITO:  estado_d = PAUSA;
      PAUSA: begin
        if (idx_q == 2'd3) begin
          estado_d = ESPERA_PIN;
`ifdef CLIENTE_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end else begin
          idx_d    = idx_q + 2'd1;
          estado_d = DIGITO;
        end
      end
      ESPERA_PIN: begin
        if (bus.bloqueo) begin
          resultado_d = RES_BLOQUEO;
          estado_d    = FIN;
        end else if (bus.pin_incorrecto) begin
          resultado_d = RES_PIN_MAL;
          estado_d    = FIN;
        end else if (bus.balance_stb) begin
          balance_d = bus.balance_actualizado;
          if (!tipo_q) begin
            resultado_d = RES_DEPOSITO;
            estado_d    = FIN;
          end else begin
            estado_d = ESPERA_RETIRO;
`ifdef CLIENTE_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
`ifdef CLIENTE_TIMEOUT_EN
        else if (expira) begin
          resultado_d = RES_TIMEOUT;
          estado_d    = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ESPERA_RETIRO: begin
        if (bus.fondos_insuficientes) begin
          resultado_d = RES_FONDOS;
          estado_d    = FIN;
        end else if (bus.entregar_dinero) begin
          resultado_d = RES_RETIRO;
          estado_d    = FIN;
        end
`ifdef CLIENTE_TIMEOUT_EN
        else if (expira) begin
          resultado_d = RES_TIMEOUT;
          estado_d    = FIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      FIN:     estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
    // Warning is sticky across every busy state, FIN included
    if (estado_q != IDLE && bus.advertencia) adv_d = 1'b1;
  end

  // Outputs decoded from state; latched request is hidden while idle
  always_comb begin
    bus.tarjeta_recibida  = (estado_q == TARJETA);
    bus.digito_stb        = (estado_q == DIGITO);
    bus.ocupado           = (estado_q != IDLE);
    bus.hecho             = (estado_q == FIN);
    bus.tipo_trans        = (estado_q != IDLE) ? tipo_q : 1'b0;
    bus.monto             = (estado_q != IDLE) ? monto_q : '0;
    bus.resultado         = resultado_q;
    bus.balance_leido     = balance_q;
    bus.advertencia_vista = adv_q;
    bus.digito            = '0;
    if (estado_q == DIGITO) begin
      case (idx_q)
        2'd0:    bus.digito = pin_q[15:12];
        2'd1:    bus.digito = pin_q[11:8];
        2'd2:    bus.digito = pin_q[7:4];
        default: bus.digito = pin_q[3:0];
      endcase
    end
  end

endmodule

// File: tb/tb_cliente_cajero.sv
// Self-checking bench for cliente_cajero: directed scenarios plus
// randomized transactions scored against a cycle-timeline model.
module tb_cliente_cajero;

  localparam int unsigned TO = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cliente_cajero_if bus ();

  cliente_cajero #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic atm_quiet();
    bus.pin_incorrecto       = 1'b0;
    bus.advertencia          = 1'b0;
    bus.bloqueo              = 1'b0;
    bus.balance_stb          = 1'b0;
    bus.entregar_dinero      = 1'b0;
    bus.fondos_insuficientes = 1'b0;
    bus.balance_actualizado  = {$urandom, $urandom};
  endtask

  function automatic logic [108:0] all_outs();
    return {bus.tarjeta_recibida, bus.digito_stb, bus.digito, bus.tipo_trans,
            bus.monto, bus.ocupado, bus.hecho, bus.resultado,
            bus.balance_leido, bus.advertencia_vista};
  endfunction

  // pr: 0 balance, 1 wrong pin, 2 bloqueo, 3 bloqueo + wrong pin
  // rr: 1 entregar, 2 fondos, 3 both
  function automatic logic [2:0] exp_result(int unsigned pr, logic tipo, int unsigned rr);
    if (pr >= 2) return 3'd4;
    if (pr == 1) return 3'd3;
    if (!tipo)   return 3'd1;
    if (rr >= 2) return 3'd5;
    return 3'd2;
  endfunction

  // Cycle k = k-th cycle after the edge that accepts iniciar.
  task automatic run_txn(input string nm, input logic [15:0] pin, input logic tipo,
                         input logic [31:0] mnt, input int unsigned pr,
                         input int unsigned d1, input logic [63:0] bal,
                         input int unsigned rr, input int unsigned d2,
                         input logic adv, input logic poke);
    int unsigned p, r, fin;
    logic        withdraw;
    logic [2:0]  er;
    logic [63:0] eb;
    p        = 10 + d1;
    withdraw = (pr == 0) && tipo;
    r        = p + 1 + d2;
    fin      = withdraw ? r + 1 : p + 1;
    er       = exp_result(pr, tipo, rr);
    eb       = (pr == 0) ? bal : 64'd0;

    atm_quiet();
    bus.pin_usuario   = pin;
    bus.tipo_usuario  = tipo;
    bus.monto_usuario = mnt;
    bus.iniciar       = 1'b1;
    tick();
    for (int unsigned k = 1; k <= fin; k++) begin
      logic        es;
      logic [3:0]  ed;
      logic [15:0] sh;
      atm_quiet();
      bus.iniciar       = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.pin_usuario   = 16'($urandom);
      bus.tipo_usuario  = 1'($urandom);
      bus.monto_usuario = $urandom;
      if (k < 10) begin
        bus.pin_incorrecto       = 1'($urandom);
        bus.bloqueo              = 1'($urandom);
        bus.balance_stb          = 1'($urandom);
        bus.entregar_dinero      = 1'($urandom);
        bus.fondos_insuficientes = 1'($urandom);
      end
      if (k == p) begin
        bus.advertencia = adv;
        case (pr)
          0: begin bus.balance_stb = 1'b1; bus.balance_actualizado = bal; end
          1: begin bus.pin_incorrecto = 1'b1; bus.balance_stb = 1'($urandom); end
          2: begin bus.bloqueo = 1'b1; bus.balance_stb = 1'($urandom); end
          default: begin bus.bloqueo = 1'b1; bus.pin_incorrecto = 1'b1;
                         bus.balance_stb = 1'($urandom); end
        endcase
      end
      if (withdraw && k > p && k < r) begin
        bus.pin_incorrecto = 1'($urandom);
        bus.bloqueo        = 1'($urandom);
        bus.balance_stb    = 1'($urandom);
      end
      if (withdraw && k == r) begin
        bus.entregar_dinero      = (rr != 2);
        bus.fondos_insuficientes = (rr >= 2);
      end
      es = (k >= 2) && (k <= 8) && (k % 2 == 0);
      ed = 4'd0;
      if (es) begin
        sh = pin >> (4 * (3 - (k - 2) / 2));
        ed = sh[3:0];
      end

      checks++;
      if (bus.tarjeta_recibida !== (k == 1)) begin
        errors++; $display("FAIL %s tarjeta k=%0d got %b exp %b", nm, k, bus.tarjeta_recibida, (k == 1));
      end
      checks++;
      if (bus.digito_stb !== es || bus.digito !== ed) begin
        errors++; $display("FAIL %s digito k=%0d got stb=%b d=%h exp stb=%b d=%h", nm, k, bus.digito_stb, bus.digito, es, ed);
      end
      checks++;
      if (bus.ocupado !== 1'b1 || bus.hecho !== (k == fin)) begin
        errors++; $display("FAIL %s ocupado/hecho k=%0d got %b/%b exp 1/%b", nm, k, bus.ocupado, bus.hecho, (k == fin));
      end
      checks++;
      if (bus.tipo_trans !== tipo || bus.monto !== mnt) begin
        errors++; $display("FAIL %s latch k=%0d got %b/%0d exp %b/%0d", nm, k, bus.tipo_trans, bus.monto, tipo, mnt);
      end
      if (k < fin) begin
        checks++;
        if (bus.resultado !== 3'd0) begin
          errors++; $display("FAIL %s resultado_early k=%0d got %b exp 000", nm, k, bus.resultado);
        end
      end else begin
        checks++;
        if (bus.resultado !== er || bus.balance_leido !== eb || bus.advertencia_vista !== adv) begin
          errors++; $display("FAIL %s final got res=%b bal=%0d adv=%b exp res=%b bal=%0d adv=%b",
                             nm, bus.resultado, bus.balance_leido, bus.advertencia_vista, er, eb, adv);
        end
      end
      tick();
    end
    atm_quiet();
    bus.iniciar = 1'b0;
    checks++;
    if (bus.ocupado !== 1'b0 || bus.hecho !== 1'b0 || bus.tipo_trans !== 1'b0 ||
        bus.monto !== 32'd0 || bus.resultado !== er || bus.balance_leido !== eb ||
        bus.advertencia_vista !== adv) begin
      errors++; $display("FAIL %s idle_after got ocu=%b hecho=%b tipo=%b monto=%0d res=%b bal=%0d adv=%b exp 0/0/0/0/%b/%0d/%b",
                         nm, bus.ocupado, bus.hecho, bus.tipo_trans, bus.monto, bus.resultado,
                         bus.balance_leido, bus.advertencia_vista, er, eb, adv);
    end
    tick();
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    atm_quiet();
    bus.iniciar = 1'b1;
    bus.pin_usuario = 16'h9876; bus.tipo_usuario = 1'b1; bus.monto_usuario = 32'd77;
    repeat (3) tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outs got %h exp 0", all_outs());
    end
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_release got %h exp 0", all_outs());
    end
    tick();
  endtask

  task automatic test_deposit();
    run_txn("deposit", 16'h1234, 1'b0, 32'd500, 0, 0, 64'd1500, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_withdrawal();
    run_txn("withdrawal", 16'h4321, 1'b1, 32'd200, 0, 0, 64'd800, 1, 2, 1'b0, 1'b0);
  endtask

  task automatic test_wrong_pin();
    run_txn("wrong_pin", 16'h0909, 1'b0, 32'd10, 1, 3, 64'd5, 0, 0, 1'b1, 1'b0);
    run_txn("bloqueo", 16'h0909, 1'b1, 32'd10, 3, 0, 64'd5, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_fondos_and_ignore();
    run_txn("fondos_both", 16'h5678, 1'b1, 32'd999, 0, 1, 64'hFFFF_0000_1234_5678, 3, 4, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int unsigned strobes;
    atm_quiet();
    bus.pin_usuario = 16'hA5C3; bus.tipo_usuario = 1'b1; bus.monto_usuario = 32'd42;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
    repeat (4) tick();
    reset = 1'b0;
    tick();
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_mid_outs got %h exp 0", all_outs());
    end
    reset = 1'b1;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.digito_stb || bus.ocupado) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      errors++; $display("FAIL reset_mid_quiet got %0d active cycles exp 0", strobes);
    end
    run_txn("after_reset", 16'hA5C3, 1'b0, 32'd42, 0, 2, 64'd3, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_silent_atm();
    atm_quiet();
    bus.pin_usuario = 16'h1111; bus.tipo_usuario = 1'b0; bus.monto_usuario = 32'd1;
    bus.iniciar = 1'b1;
    tick();
    bus.iniciar = 1'b0;
`ifdef CLIENTE_TIMEOUT_EN
    for (int unsigned k = 1; k <= 10 + TO; k++) begin
      atm_quiet();
      checks++;
      if (bus.hecho !== (k == 10 + TO)) begin
        errors++; $display("FAIL timeout_hecho k=%0d got %b exp %b", k, bus.hecho, (k == 10 + TO));
      end
      if (k == 10 + TO) begin
        checks++;
        if (bus.resultado !== 3'b110) begin
          errors++; $display("FAIL timeout_code got %b exp 110", bus.resultado);
        end
      end
      tick();
    end
`else
    begin
      int unsigned busy;
      busy = 0;
      for (int i = 0; i < 200; i++) begin
        atm_quiet();
        if (bus.ocupado === 1'b1 && bus.hecho === 1'b0) busy++;
        tick();
      end
      checks++;
      if (busy != 200) begin
        errors++; $display("FAIL wait_forever got %0d busy cycles exp 200", busy);
      end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      int unsigned pr, rr;
      pr = $urandom_range(0, 5);
      if (pr > 3) pr = 0;
      rr = $urandom_range(1, 3);
      run_txn("random", 16'($urandom), 1'($urandom), $urandom, pr,
              $urandom_range(0, TO - 1), {$urandom, $urandom}, rr,
              $urandom_range(0, TO - 1), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    bus.iniciar = 1'b0;
    bus.pin_usuario = '0; bus.tipo_usuario = 1'b0; bus.monto_usuario = '0;
    atm_quiet();
    test_reset();
    test_deposit();
    test_withdrawal();
    test_wrong_pin();
    test_fondos_and_ignore();
    test_reset_mid();
    test_silent_atm();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
